// File: rtl/enigma_rotor_ctrl.sv
// Rotor-stepping controller for the Enigma datapath.
// Holds the rotor start/notch configuration, sequences one message of
// symb_numb_i symbols and advances the three rotors with true Enigma
// stepping (including the middle-rotor double step) each time the core
// consumes a symbol.
module enigma_rotor_ctrl #(
  parameter int ALPHA = 26,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_val_i,
  input  logic [14:0]      cfg_pos_i,
  input  logic [14:0]      cfg_notch_i,
  input  logic [CNT_W-1:0] symb_numb_i,
  input  logic             start_i,
  input  logic             step_i,
  output logic [4:0]       pos_r_o,
  output logic [4:0]       pos_m_o,
  output logic [4:0]       pos_l_o,
  output logic             pos_val_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             cfg_err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0] LAST = 5'(ALPHA - 1);

  state_t           state;
  state_t           state_nxt;
  logic [4:0]       pos_r;
  logic [4:0]       pos_m;
  logic [4:0]       pos_l;
  logic [4:0]       notch_r;
  logic [4:0]       notch_m;
  logic [4:0]       notch_l;
  logic             cfg_loaded;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             cfg_err;
  logic             cfg_ok;
  logic             load_cfg;
  logic             load_start;
  logic             do_step;
  logic             flag_err;
  logic             step_m;
  logic             step_l;

  function automatic logic [4:0] advance(input logic [4:0] p);
    return (p == LAST) ? 5'd0 : p + 5'd1;
  endfunction

  // A configuration is accepted only if every field names a real letter.
  assign cfg_ok = (cfg_pos_i[4:0]     <= LAST) && (cfg_pos_i[9:5]     <= LAST) &&
                  (cfg_pos_i[14:10]   <= LAST) && (cfg_notch_i[4:0]   <= LAST) &&
                  (cfg_notch_i[9:5]   <= LAST) && (cfg_notch_i[14:10] <= LAST);

  assign cnt_inc = cnt + CNT_W'(1);

  // Middle rotor turns on right-notch carry or on its own notch (double step);
  // left rotor turns only when the middle rotor sits on its notch.
  assign step_m = (pos_r == notch_r) || (pos_m == notch_m);
  assign step_l = (pos_m == notch_m);

  // Next-state and control decode; config wins over start when both arrive.
  always_comb begin
    state_nxt  = state;
    load_cfg   = 1'b0;
    load_start = 1'b0;
    do_step    = 1'b0;
    flag_err   = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_val_i) begin
          if (cfg_ok) load_cfg = 1'b1;
          else        flag_err = 1'b1;
        end else if (start_i) begin
          if (cfg_loaded) begin
            load_start = 1'b1;
            state_nxt  = (symb_numb_i != '0) ? RUN : DONE;
          end else begin
            flag_err = 1'b1;
          end
        end
      end
      RUN: begin
        if (step_i) begin
          do_step = 1'b1;
          if (cnt_inc == len) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Configuration, message length/counter and rotor positions.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pos_r      <= '0;
      pos_m      <= '0;
      pos_l      <= '0;
      notch_r    <= '0;
      notch_m    <= '0;
      notch_l    <= '0;
      cfg_loaded <= 1'b0;
      len        <= '0;
      cnt        <= '0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err <= flag_err;
      if (load_cfg) begin
        pos_r      <= cfg_pos_i[4:0];
        pos_m      <= cfg_pos_i[9:5];
        pos_l      <= cfg_pos_i[14:10];
        notch_r    <= cfg_notch_i[4:0];
        notch_m    <= cfg_notch_i[9:5];
        notch_l    <= cfg_notch_i[14:10];
        cfg_loaded <= 1'b1;
      end
      if (load_start) begin
        len <= symb_numb_i;
        cnt <= '0;
      end
      if (do_step) begin
        pos_r <= advance(pos_r);
        if (step_m) pos_m <= advance(pos_m);
        if (step_l) pos_l <= advance(pos_l);
        cnt <= cnt_inc;
      end
    end
  end

  assign pos_r_o   = pos_r;
  assign pos_m_o   = pos_m;
  assign pos_l_o   = pos_l;
  assign pos_val_o = (state == RUN);
  assign busy_o    = (state == RUN) || (state == DONE);
  assign done_o    = (state == DONE);
  assign cfg_err_o = cfg_err;

endmodule

// File: tb/tb_enigma_rotor_ctrl.sv
// Self-checking bench for enigma_rotor_ctrl: an odometer-style model of the
// rotors is compared against the DUT on every falling edge, and directed
// scenarios pin both model and DUT to hand-computed positions.
module tb_enigma_rotor_ctrl;

  localparam int ALPHA = 26;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             cfg_val;
  logic [14:0]      cfg_pos;
  logic [14:0]      cfg_notch;
  logic [CNT_W-1:0] symb_numb;
  logic             start;
  logic             step;
  logic [4:0]       pos_r;
  logic [4:0]       pos_m;
  logic [4:0]       pos_l;
  logic             pos_val;
  logic             busy;
  logic             done;
  logic             cfg_err;

  int n_checks = 0;
  int n_fail   = 0;

  enigma_rotor_ctrl #(.ALPHA(ALPHA), .CNT_W(CNT_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cfg_val_i   (cfg_val),
    .cfg_pos_i   (cfg_pos),
    .cfg_notch_i (cfg_notch),
    .symb_numb_i (symb_numb),
    .start_i     (start),
    .step_i      (step),
    .pos_r_o     (pos_r),
    .pos_m_o     (pos_m),
    .pos_l_o     (pos_l),
    .pos_val_o   (pos_val),
    .busy_o      (busy),
    .done_o      (done),
    .cfg_err_o   (cfg_err)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Index 0 = right, 1 = middle, 2 = left.
  int m_pos[3];
  int m_notch[3];
  int m_remaining;
  bit m_loaded;
  bit m_running;
  bit m_done;
  bit m_err;
  bit m_was_done;
  bit m_turn_m;
  bit m_turn_l;
  bit m_fields_ok;

  function automatic int field(input logic [14:0] v, input int idx);
    return int'((v >> (5 * idx)) & 15'd31);
  endfunction

  // Model advances on the same edges as the DUT, from the inputs it sees.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_pos[i]   = 0;
        m_notch[i] = 0;
      end
      m_remaining = 0;
      m_loaded    = 0;
      m_running   = 0;
      m_done      = 0;
      m_err       = 0;
    end else begin
      m_was_done = m_done;
      m_done     = 0;
      m_err      = 0;
      if (m_running) begin
        if (step) begin
          m_turn_m = (m_pos[0] == m_notch[0]) || (m_pos[1] == m_notch[1]);
          m_turn_l = (m_pos[1] == m_notch[1]);
          m_pos[0] = (m_pos[0] + 1) % ALPHA;
          if (m_turn_m) m_pos[1] = (m_pos[1] + 1) % ALPHA;
          if (m_turn_l) m_pos[2] = (m_pos[2] + 1) % ALPHA;
          m_remaining--;
          if (m_remaining == 0) begin
            m_running = 0;
            m_done    = 1;
          end
        end
      end else if (!m_was_done) begin
        if (cfg_val) begin
          m_fields_ok = 1;
          for (int i = 0; i < 3; i++)
            if (field(cfg_pos, i) >= ALPHA || field(cfg_notch, i) >= ALPHA) m_fields_ok = 0;
          if (m_fields_ok) begin
            for (int i = 0; i < 3; i++) begin
              m_pos[i]   = field(cfg_pos, i);
              m_notch[i] = field(cfg_notch, i);
            end
            m_loaded = 1;
          end else begin
            m_err = 1;
          end
        end else if (start) begin
          if (m_loaded) begin
            m_remaining = int'(symb_numb);
            if (m_remaining == 0) m_done = 1;
            else                  m_running = 1;
          end else begin
            m_err = 1;
          end
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Continuous comparison of DUT against the model away from the active edge.
  always @(negedge clk) begin
    check("cyc pos_r", int'(pos_r), m_pos[0]);
    check("cyc pos_m", int'(pos_m), m_pos[1]);
    check("cyc pos_l", int'(pos_l), m_pos[2]);
    check("cyc pos_val", int'(pos_val), int'(m_running));
    check("cyc busy", int'(busy), int'(m_running | m_done));
    check("cyc done", int'(done), int'(m_done));
    check("cyc cfg_err", int'(cfg_err), int'(m_err));
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [14:0] pack(input int l, input int m, input int r);
    return {5'(l), 5'(m), 5'(r)};
  endfunction

  // Drive one cycle of inputs, then drop the strobes 2 time units after the edge.
  task automatic applyStimulus(input logic cv, input logic [14:0] p, input logic [14:0] n,
                               input logic [CNT_W-1:0] sn, input logic st, input logic stp);
    cfg_val   = cv;
    cfg_pos   = p;
    cfg_notch = n;
    symb_numb = sn;
    start     = st;
    step      = stp;
    @(posedge clk);
    #2;
    cfg_val = 1'b0;
    start   = 1'b0;
    step    = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Literal expectations; positions also pin the model.
  task automatic checkOutput(input string name, input int l, input int m, input int r,
                             input bit val, input bit bsy, input bit dn, input bit err);
    check({name, " pos_l"}, int'(pos_l), l);
    check({name, " pos_m"}, int'(pos_m), m);
    check({name, " pos_r"}, int'(pos_r), r);
    check({name, " pos_val"}, int'(pos_val), int'(val));
    check({name, " busy"}, int'(busy), int'(bsy));
    check({name, " done"}, int'(done), int'(dn));
    check({name, " cfg_err"}, int'(cfg_err), int'(err));
    check({name, " model_l"}, m_pos[2], l);
    check({name, " model_m"}, m_pos[1], m);
    check({name, " model_r"}, m_pos[0], r);
  endtask

  task automatic doReset();
    rst = 1'b1;
    #1;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  int gaps[4] = '{0, 3, 5, 1};

  initial begin
    rst       = 1'b1;
    cfg_val   = 1'b0;
    cfg_pos   = '0;
    cfg_notch = '0;
    symb_numb = '0;
    start     = 1'b0;
    step      = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("reset", 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] start before config");
    applyStimulus(1'b0, '0, '0, 8'd3, 1'b1, 1'b0);
    checkOutput("nocfg start", 0, 0, 0, 0, 0, 0, 1);
    idleCycles(1);
    checkOutput("nocfg after", 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] invalid config");
    applyStimulus(1'b1, pack(1, 2, 26), pack(0, 0, 0), 8'd0, 1'b0, 1'b0);
    checkOutput("badcfg", 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(1'b0, '0, '0, 8'd2, 1'b1, 1'b0);
    checkOutput("badcfg start", 0, 0, 0, 0, 0, 0, 1);

    $display("[TB] double step");
    applyStimulus(1'b1, pack(0, 3, 20), pack(16, 4, 21), 8'd0, 1'b0, 1'b0);
    checkOutput("ds cfg", 0, 3, 20, 0, 0, 0, 0);
    applyStimulus(1'b0, '0, '0, 8'd3, 1'b1, 1'b0);
    checkOutput("ds start", 0, 3, 20, 1, 1, 0, 0);
    applyStimulus(1'b0, '0, '0, 8'd0, 1'b0, 1'b1);
    checkOutput("ds step1", 0, 3, 21, 1, 1, 0, 0);
    applyStimulus(1'b0, '0, '0, 8'd0, 1'b0, 1'b1);
    checkOutput("ds step2", 0, 4, 22, 1, 1, 0, 0);
    applyStimulus(1'b0, '0, '0, 8'd0, 1'b0, 1'b1);
    checkOutput("ds step3", 1, 5, 23, 0, 1, 1, 0);
    idleCycles(1);
    checkOutput("ds idle", 1, 5, 23, 0, 0, 0, 0);

    $display("[TB] second message continues from final positions");
    applyStimulus(1'b0, '0, '0, 8'd1, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, 8'd0, 1'b0, 1'b1);
    checkOutput("cont step", 1, 5, 24, 0, 1, 1, 0);
    idleCycles(1);

    $display("[TB] wrap-around");
    applyStimulus(1'b1, pack(25, 25, 25), pack(0, 0, 0), 8'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 8'd1, 1'b1, 1'b0);
    checkOutput("wrap start", 25, 25, 25, 1, 1, 0, 0);
    applyStimulus(1'b0, '0, '0, 8'd0, 1'b0, 1'b1);
    checkOutput("wrap step", 25, 25, 0, 0, 1, 1, 0);
    idleCycles(1);
    checkOutput("wrap idle", 25, 25, 0, 0, 0, 0, 0);

    $display("[TB] zero-length message");
    applyStimulus(1'b1, pack(4, 5, 6), pack(1, 1, 1), 8'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 8'd0, 1'b1, 1'b0);
    checkOutput("zero done", 4, 5, 6, 0, 1, 1, 0);
    idleCycles(1);
    checkOutput("zero idle", 4, 5, 6, 0, 0, 0, 0);

    $display("[TB] step outside RUN and cfg+start same cycle");
    applyStimulus(1'b0, '0, '0, 8'd0, 1'b0, 1'b1);
    checkOutput("idle step", 4, 5, 6, 0, 0, 0, 0);
    applyStimulus(1'b1, pack(2, 7, 10), pack(5, 9, 0), 8'd4, 1'b1, 1'b0);
    checkOutput("cfg+start", 2, 7, 10, 0, 0, 0, 0);

    $display("[TB] gapped steps with ignored cfg/start");
    applyStimulus(1'b0, '0, '0, 8'd4, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < gaps[i]; j++)
        applyStimulus(j == 0, pack(0, 0, 0), pack(1, 1, 1), 8'd9, j == 1, 1'b0);
      checkOutput("gap hold", 2, 7, 10 + i, 1, 1, 0, 0);
      applyStimulus(1'b0, '0, '0, 8'd0, 1'b0, 1'b1);
      checkOutput("gap step", 2, 7, 11 + i, (i != 3), 1, (i == 3), 0);
    end
    applyStimulus(1'b1, pack(0, 0, 0), pack(1, 1, 1), 8'd0, 1'b0, 1'b0);
    checkOutput("cfg in done", 2, 7, 14, 0, 0, 0, 0);

    $display("[TB] reset mid-message");
    applyStimulus(1'b1, pack(0, 0, 0), pack(10, 10, 10), 8'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 8'd5, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, 8'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 8'd0, 1'b0, 1'b1);
    checkOutput("mid run", 0, 0, 2, 1, 1, 0, 0);
    rst = 1'b1;
    #1;
    checkOutput("mid reset", 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    applyStimulus(1'b0, '0, '0, 8'd5, 1'b1, 1'b0);
    checkOutput("post reset start", 0, 0, 0, 0, 0, 0, 1);
    idleCycles(2);

    doReset();
    checkOutput("final reset", 0, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/enigma_rotor_ctrl.md
Name: enigma_rotor_ctrl

Overview:
Rotor-stepping controller for the Enigma datapath. It latches the initial rotor positions and notch positions, then sequences one message of symb_numb_i symbols. On each symbol the enigma core consumes, it advances the three rotor positions with true Enigma stepping, including the middle-rotor double step. It sits beside the input/output buffering wrapper and drives the core's rotor-position inputs.

Parameters:
ALPHA, 26, alphabet size; positions range 0..ALPHA-1.
CNT_W, 8, width of the message symbol counter and of symb_numb_i.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
cfg_val_i  in  1  config strobe: latch cfg_pos_i / cfg_notch_i
cfg_pos_i  in  15  initial positions: [4:0] right, [9:5] middle, [14:10] left
cfg_notch_i  in  15  notch (turnover) positions, same packing
symb_numb_i  in  CNT_W  number of symbols in the message; sampled on start
start_i  in  1  start message sequencing
step_i  in  1  core consumed one symbol (connect to the wrapper's en_val)
pos_r_o  out  5  right rotor position
pos_m_o  out  5  middle rotor position
pos_l_o  out  5  left rotor position
pos_val_o  out  1  positions valid (state RUN)
busy_o  out  1  state is RUN or DONE
done_o  out  1  one-cycle pulse at message end
cfg_err_o  out  1  one-cycle pulse on rejected config or start

Behaviour:
- Reset state: FSM=IDLE, config cleared, cfg_loaded=0, counter=0. All outputs are 0.
- FSM states: IDLE, RUN, DONE.
- IDLE, cfg_val_i=1:
  - If all six 5-bit fields are < ALPHA: latch positions into pos_*_o, latch notches internally, set cfg_loaded=1.
  - Otherwise: pulse cfg_err_o the next cycle and keep the previous config.
- IDLE, start_i=1 (cfg_val_i=0):
  - If cfg_loaded=1: latch symb_numb_i into a length register, cnt<=0. Go to RUN if the length is nonzero, else go to DONE.
  - If cfg_loaded=0: pulse cfg_err_o and stay in IDLE.
- Same cycle cfg_val_i=1 and start_i=1 in IDLE: config is processed, start is ignored.
- RUN, step_i=1: positions update the next cycle; all decisions use pre-step values.
  - Right rotor always steps.
  - Middle rotor steps if right==notch_r OR middle==notch_m (double step).
  - Left rotor steps if middle==notch_m.
  - Step is (p==ALPHA-1) ? 0 : p+1.
  - cnt<=cnt+1. If cnt+1 == length, go to DONE.
- RUN, step_i=0: positions hold. There is no timeout.
- DONE: lasts exactly one cycle. done_o=1, pos_val_o=0, positions hold. Then go to IDLE with cfg_loaded still 1.
- Positions persist between messages. A second start continues from the final positions unless a new config is loaded.
- cfg_val_i and start_i in RUN or DONE: ignored, no error.
- step_i outside RUN: ignored.
- pos_val_o=1 exactly while in RUN. busy_o=1 in RUN and DONE. Outputs are registered; there is no combinational path from inputs to outputs.
- Reset asserted mid-message: immediate return to the reset state; config is lost.

Test Plan:
- Double step: cfg pos (l,m,r)=(0,3,20), notch (16,4,21), length 3, three step_i pulses -> positions (0,3,21), (0,4,22), (1,5,23); done_o pulses one cycle after the third step.
- Wrap-around: pos (25,25,25), notch (0,0,0), length 1, one step -> (25,25,0); middle and left hold; then the FSM returns to IDLE.
- Error handling:
  - cfg_pos_i right field = 26 -> cfg_err_o pulses and cfg_loaded stays 0.
  - start_i before any config -> cfg_err_o pulses and pos_val_o stays 0.
- symb_numb_i=0: start -> DONE on the next cycle, done_o=1, positions unchanged, pos_val_o never asserts.
- Gapped steps: length 4 with step_i spaced 0-5 idle cycles apart -> exactly 4 right-rotor increments; cfg_val_i/start_i pulses during RUN have no effect.
- Reset mid-message: rst_i asserted after 2 of 5 steps -> all outputs 0 immediately; the next start without config -> cfg_err_o.
